multi_cycle_ctr: RTL and testbench

MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

---
 rtl/multi_cycle_ctr.sv | 185 ++++++++++++++++++
 tb/tb_multi_cycle_ctr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctr.sv
// Main control unit for a multi-cycle MIPS-style datapath: a Moore FSM that
// sequences fetch, decode, execute, memory and write-back for each instruction.
module multi_cycle_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [1:0] PCSource,
    output logic [1:0] ALUop,
    output logic [5:0] ALUfunc,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LWWB   = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Codes 12-15 fall into the default arm and recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                           state_d = S_MEMADR;
                    OP_RTYPE:                               state_d = S_REXE;
                    OP_BEQ:                                 state_d = S_BEQ;
                    OP_J:                                   state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                    OP_XORI:                                state_d = S_IEXE;
                    default:                                state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_LWWB : S_MEMRD;
            S_LWWB:   state_d = S_FETCH;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_REXE:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXE:   state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the state register; only PCEn/IRWrite/Illegal
    // look at MemReady, Zero or the opcode legality directly.
    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtOp    = 1'b0;
        PCSource = 2'b00;
        ALUop    = 2'b00;
        ALUfunc  = 6'b000000;
        Illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUop   = 2'b11;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ExtOp   = 1'b1;
                ALUop   = 2'b11;
                Illegal = ~op_legal(Op);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 1'b1;
                ALUop   = 2'b11;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LWWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXE: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b01;
                ALUfunc = Func;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 1'b1;
                ALUop    = 2'b10;
                PCSource = 2'b01;
                PCEn     = Zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUfunc = {2'b00, Op[3:0]};
                // Logical immediates zero-extend; arithmetic ones sign-extend.
                ExtOp   = !((Op == OP_ANDI) || (Op == OP_ORI) || (Op == OP_XORI));
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Bench for multi_cycle_ctr: directed instruction traces plus randomized
// instruction streams compared against a per-instruction state/output model.
module tb_multi_cycle_ctr;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, ExtOp, Illegal;
    logic [1:0] ALUSrcB, PCSource, ALUop;
    logic [5:0] ALUfunc;
    logic [3:0] State;

    int n_chk  = 0;
    int n_pass = 0;

    multi_cycle_ctr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Op       (Op),
        .Func     (Func),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ExtOp    (ExtOp),
        .PCSource (PCSource),
        .ALUop    (ALUop),
        .ALUfunc  (ALUfunc),
        .Illegal  (Illegal),
        .State    (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] outs_act;
    assign outs_act = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                       RegWrite, ALUSrcA, ALUSrcB, ExtOp, PCSource, ALUop, ALUfunc, Illegal};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit is_iarith(input logic [5:0] op);
        return op == 6'b001000 || op == 6'b001010 || op == 6'b001100 ||
               op == 6'b001101 || op == 6'b001110;
    endfunction

    // Expected control word for a given state, written from the per-state
    // signal table; everything not named stays 0.
    function automatic logic [22:0] exp_outs(input int st, input logic [5:0] op,
                                             input logic [5:0] fn, input bit mr, input bit z);
        logic       pcen = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0;
        logic       srca = 0, ext = 0, ill = 0;
        logic [1:0] srcb = 0, pcs = 0, aop = 0;
        logic [5:0] afn = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; aop = 2'b11; irw = mr; pcen = mr; end
            1:  begin srcb = 2'b11; ext = 1; aop = 2'b11;
                      ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                              op == 6'b000100 || op == 6'b000010 || is_iarith(op)); end
            2:  begin srca = 1; srcb = 2'b10; ext = 1; aop = 2'b11; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b01; afn = fn; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b10; pcs = 2'b01; pcen = z; end
            9:  begin pcs = 2'b10; pcen = 1; end
            10: begin srca = 1; srcb = 2'b10; aop = 2'b00; afn = {2'b00, op[3:0]};
                      ext = !(op == 6'b001100 || op == 6'b001101 || op == 6'b001110); end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, ext, pcs, aop, afn, ill};
    endfunction

    // Builds the expected state walk of one instruction (fw/mw = number of
    // MemReady-low samples in FETCH and in the memory state), then plays it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input bit z, input string name);
        int sts[$];
        bit mrs[$];
        for (int k = 0; k < fw; k++) begin sts.push_back(0); mrs.push_back(1'b0); end
        sts.push_back(0); mrs.push_back(1'b1);
        sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
        if (op == 6'b100011 || op == 6'b101011) begin
            int mst = (op == 6'b100011) ? 3 : 5;
            sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k < mw; k++) begin sts.push_back(mst); mrs.push_back(1'b0); end
            sts.push_back(mst); mrs.push_back(1'b1);
            if (op == 6'b100011) begin sts.push_back(4); mrs.push_back(1'($urandom_range(0, 1))); end
        end else if (op == 6'b000000) begin
            sts.push_back(6); mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(7); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'b000100) begin
            sts.push_back(8); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (op == 6'b000010) begin
            sts.push_back(9); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (is_iarith(op)) begin
            sts.push_back(10); mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(11); mrs.push_back(1'($urandom_range(0, 1)));
        end
        foreach (sts[i]) begin
            @(negedge clk);
            Op       = op;
            Func     = fn;
            MemReady = mrs[i];
            Zero     = (sts[i] == 8) ? z : 1'($urandom_range(0, 1));
            #1;
            check_val($sformatf("%s state c%0d", name, i), 32'(State), 32'(sts[i]));
            check_val($sformatf("%s outs c%0d st%0d", name, i, sts[i]), 32'(outs_act),
                      32'(exp_outs(sts[i], op, fn, MemReady, Zero)));
        end
    endtask

    task automatic reset_mid_memwr();
        int seq[5] = '{0, 1, 2, 5, 5};
        bit mr[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        Op = 6'b101011;
        Func = 6'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            MemReady = mr[i];
            #1;
            check_val($sformatf("sw_rst state c%0d", i), 32'(State), 32'(seq[i]));
        end
        check_val("sw_rst MemWrite waiting", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async rst State", 32'(State), 32'd0);
        check_val("async rst MemWrite", 32'(MemWrite), 32'd0);
        check_val("async rst MemRead", 32'(MemRead), 32'd1);
        check_val("async rst outs", 32'(outs_act), 32'(exp_outs(0, Op, Func, 1'b0, Zero)));
        @(posedge clk);
        #1;
        check_val("rst held State", 32'(State), 32'd0);
        check_val("rst held no writes", 32'({RegWrite, MemWrite, PCEn}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                   6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};

    initial begin
        rst_n    = 1'b0;
        Op       = 6'h00;
        Func     = 6'h00;
        Zero     = 1'b0;
        MemReady = 1'b0;
        #1;
        check_val("reset State", 32'(State), 32'd0);
        check_val("reset outs", 32'(outs_act), 32'(exp_outs(0, 6'h00, 6'h00, 1'b0, 1'b0)));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, "add");
        run_instr(6'b100011, 6'h00,     0, 2, 1'b0, "lw_wait2");
        run_instr(6'b000100, 6'h00,     0, 0, 1'b1, "beq_z1");
        run_instr(6'b000100, 6'h00,     0, 0, 1'b0, "beq_z0");
        run_instr(6'b001101, 6'h15,     0, 0, 1'b0, "ori");
        run_instr(6'b111111, 6'h00,     0, 0, 1'b0, "illegal");
        run_instr(6'b000010, 6'h00,     1, 0, 1'b0, "j_fwait");
        run_instr(6'b101011, 6'h00,     0, 1, 1'b0, "sw_wait1");
        run_instr(6'b001000, 6'h00,     0, 0, 1'b0, "addi");

        reset_mid_memwr();
        run_instr(6'b000000, 6'b100010, 0, 0, 1'b0, "sub_after_rst");

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)]
                                            : 6'($urandom_range(0, 63));
            run_instr(op, 6'($urandom_range(0, 63)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        @(negedge clk);
        MemReady = 1'b0;
        #1;
        check_val("final State", 32'(State), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
